uart_reg_responder: RTL and testbench
=====================================

// Module: uart_reg_responder
// PURPOSE
// - Host-side responder on the far end of the UART FIFO interface: drains the RX FIFO (rx_empty/rx_rd_en/rx_data) and fills the TX FIFO (tx_full/tx_wr_en/tx_data).
// - Parses 5-byte request frames, executes register read/write on an internal register bank, and queues a 5-byte response frame.
// - Gives a remote UART initiator access to a bank of control registers.
// PARAMETERS
// - data_bits       8    byte/register width; must be 8 for frame constants
// - num_regs        16   register count; valid addresses 0..num_regs-1
// - timeout_cycles  1000 clk cycles allowed between bytes of one frame before abort
// PORTS
// - clk            in   1                    single clock, rising edge
// - reset          in   1                    synchronous, active-high
// - rx_empty       in   1                    RX FIFO empty
// - rx_data        in   data_bits            RX FIFO dout; valid the cycle after rx_rd_en
// - rx_rd_en       out  1                    RX FIFO pop, 1-cycle pulse
// - tx_full        in   1                    TX FIFO full
// - tx_data        out  data_bits            TX FIFO din
// - tx_wr_en       out  1                    TX FIFO push, 1-cycle pulse
// - reg_q          out  num_regs*data_bits   register bank, reg i at [i*data_bits +: data_bits]
// - frame_err_cnt  out  8                    checksum+timeout error count, saturates at 255
// - busy           out  1                    1 whenever not idle with byte_idx==0
// BEHAVIOUR
// - Request frame: SOF=0xA5, CMD, ADDR, DATA, CHK = CMD^ADDR^DATA.
//   - CMD 0x01 = write, 0x02 = read; a read ignores DATA.
// - Response frame: 0x5A, STATUS, ADDR, DATA, CHK = STATUS^ADDR^DATA.
//   - STATUS: 0x00 ok, 0xE1 bad checksum, 0xE2 bad cmd, 0xE3 addr>=num_regs.
//   - Error priority: E1 > E2 > E3.
//   - Response DATA: reg value on ok read; request DATA otherwise.
// - FSM states:
//   - POP: assert rx_rd_en only when rx_empty=0; go to CAP.
//   - CAP: latch rx_data into field[byte_idx].
//     - If byte_idx==0 and byte!=0xA5: discard and stay resyncing, no response.
//     - If byte_idx<4: byte_idx++ and return to POP.
//     - If byte_idx==4: go to EXEC.
//   - EXEC: one cycle; compute status; on ok write, update reg[ADDR] at the end of this cycle; go to TX.
//   - TX: for k=0..4, drive tx_data=resp[k] with tx_wr_en=1 only in cycles where tx_full=0.
//     - Hold the byte while tx_full=1.
//     - After k=4, set byte_idx=0 and return to POP.
// - Only one rx_rd_en is ever outstanding. No pop occurs during EXEC or TX; RX backpressure comes from the FIFO filling.
// - Minimum latency: last request byte captured to first tx_wr_en = 2 cycles.
// - Timeout:
//   - The counter clears on every captured byte and counts while byte_idx!=0 and the FSM is in POP.
//   - On reaching timeout_cycles: byte_idx=0, frame_err_cnt+1, no response sent.
// - Checksum failure increments frame_err_cnt and still sends a response. Bad cmd and bad addr do not increment it.
// - Error writes never modify registers.
// - Reset (also mid-frame or mid-response): state=POP, byte_idx=0, all regs=0, frame_err_cnt=0, rx_rd_en=0, tx_wr_en=0, tx_data=0, busy=0. The partial frame is dropped.
// STRUCTURE
// - Shared package uart_pkg:
//   - constants: SOF_REQ=8'hA5, SOF_RSP=8'h5A, CMD_WR=8'h01, CMD_RD=8'h02, ST_OK/ST_BADCHK/ST_BADCMD/ST_BADADDR.
//   - responder state encoding.
// - Sub-module uart_reg_bank: num_regs x data_bits registers with sync write port, flat reg_q output and combinational read mux.
// - Frame FSM and checksum logic stay in this module.
// TESTING
// - Write: feed A5 01 03 7E 7C -> reg3=0x7E; TX gets 5A 00 03 7E 7D; frame_err_cnt=0.
// - Read: then feed A5 02 03 00 01 -> TX gets 5A 00 03 7E 7D.
// - Bad checksum: feed A5 01 03 7E 00 -> TX gets 5A E1 03 7E 9C; reg3 unchanged; frame_err_cnt=1.
// - Bad addr: feed A5 01 10 55 44 -> TX gets 5A E3 10 55 A6; no reg changes.
// - Resync/timeout: feed 00 FF then a valid write -> only one response.
//   - Then feed A5 01 and idle timeout_cycles+5 -> no TX; frame_err_cnt+1; a following valid frame is answered.
// - Backpressure/reset:
//   - Hold tx_full=1 for 20 cycles mid-response -> no tx_wr_en during that window; 5 bytes emitted in order, none lost.
//   - Assert reset after 3 request bytes -> all outputs 0; next full frame answered normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared frame constants and responder state encoding for the UART register responder.
package uart_pkg;

   localparam logic [7:0] SOF_REQ    = 8'hA5;
   localparam logic [7:0] SOF_RSP    = 8'h5A;
   localparam logic [7:0] CMD_WR     = 8'h01;
   localparam logic [7:0] CMD_RD     = 8'h02;
   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_BADCHK  = 8'hE1;
   localparam logic [7:0] ST_BADCMD  = 8'hE2;
   localparam logic [7:0] ST_BADADDR = 8'hE3;

   typedef enum logic [1:0] {
      S_POP,
      S_CAP,
      S_EXEC,
      S_TX
   } rsp_state_e;

   function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c);
      return a ^ b ^ c;
   endfunction

endpackage

// File: rtl/uart_reg_bank.sv
// Register bank: synchronous write port, combinational read mux, flat view of all registers.
module uart_reg_bank #(
   parameter int data_bits = 8,
   parameter int num_regs  = 16,
   parameter int addr_w    = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          we_i,
   input  logic [addr_w-1:0]             waddr_i,
   input  logic [data_bits-1:0]          wdata_i,
   input  logic [addr_w-1:0]             raddr_i,
   output logic [data_bits-1:0]          rdata_o,
   output logic [num_regs*data_bits-1:0] regs_o
);

   logic [data_bits-1:0] regs_q [num_regs];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < num_regs; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = regs_q[raddr_i];

   for (genvar gi = 0; gi < num_regs; gi++) begin : g_flat
      assign regs_o[gi*data_bits +: data_bits] = regs_q[gi];
   end

endmodule

// File: rtl/uart_reg_responder.sv
// Drains 5-byte request frames from the RX FIFO, executes register read/write,
// and pushes a 5-byte response frame into the TX FIFO.
module uart_reg_responder
   import uart_pkg::*;
#(
   parameter int data_bits      = 8,
   parameter int num_regs       = 16,
   parameter int timeout_cycles = 1000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx_empty,
   input  logic [data_bits-1:0]          rx_data,
   output logic                          rx_rd_en,
   input  logic                          tx_full,
   output logic [data_bits-1:0]          tx_data,
   output logic                          tx_wr_en,
   output logic [num_regs*data_bits-1:0] reg_q,
   output logic [7:0]                    frame_err_cnt,
   output logic                          busy
);

   localparam int AW = (num_regs > 1) ? $clog2(num_regs) : 1;
   localparam int TW = $clog2(timeout_cycles + 1);

   rsp_state_e           state_q, state_d;
   logic [2:0]           byte_idx_q, byte_idx_d;
   logic [2:0]           k_q, k_d;
   logic [data_bits-1:0] cmd_q, cmd_d, addr_q, addr_d, data_q, data_d, chk_q, chk_d;
   logic [data_bits-1:0] status_q, status_d, rdata_q, rdata_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [7:0]           err_q, err_d;
   logic [data_bits-1:0] status_calc, bank_rdata, resp_byte;
   logic                 bank_we;

   uart_reg_bank #(
      .data_bits(data_bits),
      .num_regs (num_regs),
      .addr_w   (AW)
   ) u_bank (
      .clk    (clk),
      .reset  (reset),
      .we_i   (bank_we),
      .waddr_i(addr_q[AW-1:0]),
      .wdata_i(data_q),
      .raddr_i(addr_q[AW-1:0]),
      .rdata_o(bank_rdata),
      .regs_o (reg_q)
   );

   // Error priority: bad checksum, then bad command, then bad address.
   always_comb begin
      status_calc = ST_OK;
      if (chk_q != frame_chk(cmd_q, addr_q, data_q)) status_calc = ST_BADCHK;
      else if (cmd_q != CMD_WR && cmd_q != CMD_RD)   status_calc = ST_BADCMD;
      else if (32'(addr_q) >= 32'(num_regs))         status_calc = ST_BADADDR;
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      k_d        = k_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      data_d     = data_q;
      chk_d      = chk_q;
      status_d   = status_q;
      rdata_d    = rdata_q;
      tmo_d      = tmo_q;
      err_d      = err_q;
      bank_we    = 1'b0;
      case (state_q)
         S_POP: begin
            if (!rx_empty) begin
               state_d = S_CAP;
            end else if (byte_idx_q != 3'd0) begin
               if (tmo_q == TW'(timeout_cycles - 1)) begin
                  byte_idx_d = 3'd0;
                  tmo_d      = '0;
                  err_d      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end
         S_CAP: begin
            tmo_d   = '0;
            state_d = S_POP;
            case (byte_idx_q)
               3'd0:    if (rx_data == SOF_REQ) byte_idx_d = 3'd1;
               3'd1:    begin cmd_d  = rx_data; byte_idx_d = 3'd2; end
               3'd2:    begin addr_d = rx_data; byte_idx_d = 3'd3; end
               3'd3:    begin data_d = rx_data; byte_idx_d = 3'd4; end
               default: begin chk_d  = rx_data; state_d = S_EXEC; end
            endcase
         end
         S_EXEC: begin
            status_d = status_calc;
            rdata_d  = (status_calc == ST_OK && cmd_q == CMD_RD) ? bank_rdata : data_q;
            bank_we  = (status_calc == ST_OK && cmd_q == CMD_WR);
            if (status_calc == ST_BADCHK) err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            k_d      = 3'd0;
            state_d  = S_TX;
         end
         default: begin
            if (!tx_full) begin
               if (k_q == 3'd4) begin
                  k_d        = 3'd0;
                  byte_idx_d = 3'd0;
                  state_d    = S_POP;
               end else begin
                  k_d = k_q + 3'd1;
               end
            end
         end
      endcase
   end

   always_comb begin
      case (k_q)
         3'd0:    resp_byte = SOF_RSP;
         3'd1:    resp_byte = status_q;
         3'd2:    resp_byte = addr_q;
         3'd3:    resp_byte = rdata_q;
         default: resp_byte = frame_chk(status_q, addr_q, rdata_q);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_POP;
         byte_idx_q <= '0;
         k_q        <= '0;
         cmd_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         chk_q      <= '0;
         status_q   <= '0;
         rdata_q    <= '0;
         tmo_q      <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         k_q        <= k_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         chk_q      <= chk_d;
         status_q   <= status_d;
         rdata_q    <= rdata_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
      end
   end

   // Strobes are gated by reset so every handshake output reads 0 while reset is held.
   assign rx_rd_en      = !reset && state_q == S_POP && !rx_empty;
   assign tx_wr_en      = !reset && state_q == S_TX && !tx_full;
   assign tx_data       = (!reset && state_q == S_TX) ? resp_byte : '0;
   assign busy          = !reset && !(state_q == S_POP && byte_idx_q == 3'd0);
   assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench: stimulus queues request bytes and expected response bytes,
// a monitor pops and compares every TX FIFO push.
module tb_uart_reg_responder;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         rx_empty = 1'b1;
   logic [7:0]   rx_data = 8'h00;
   logic         rx_rd_en;
   logic         tx_full = 1'b0;
   logic [7:0]   tx_data;
   logic         tx_wr_en;
   logic [127:0] reg_q;
   logic [7:0]   frame_err_cnt;
   logic         busy;

   logic [7:0]   rx_fifo[$];
   logic [7:0]   exp_q[$];
   logic [127:0] exp_regs = '0;
   int           checks = 0;
   int           failures = 0;
   int           tx_seen = 0;
   int           win_wr = 0;
   bit           in_window = 1'b0;

   uart_reg_responder dut (
      .clk          (clk),
      .reset        (reset),
      .rx_empty     (rx_empty),
      .rx_data      (rx_data),
      .rx_rd_en     (rx_rd_en),
      .tx_full      (tx_full),
      .tx_data      (tx_data),
      .tx_wr_en     (tx_wr_en),
      .reg_q        (reg_q),
      .frame_err_cnt(frame_err_cnt),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // RX FIFO model: dout valid the cycle after the pop.
   always @(posedge clk) begin
      if (reset) rx_fifo.delete();
      else if (rx_rd_en && rx_fifo.size() > 0) rx_data <= rx_fifo.pop_front();
      rx_empty <= (rx_fifo.size() == 0);
   end

   // Monitor: compare every TX push against the scoreboard queue.
   always @(negedge clk) begin
      if (in_window && tx_wr_en) win_wr++;
      if (tx_wr_en) begin
         tx_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_tx got=%02h required=no_byte", tx_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (tx_data !== e) begin
               failures++;
               $display("FAIL tx_byte got=%02h required=%02h", tx_data, e);
            end else begin
               $display("tx byte %02h ok", tx_data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%0h required=%0h", name, act, req);
      end else begin
         $display("check %s = %0h ok", name, act);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_fifo.push_back(b);
   endtask

   task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4);
      push_byte(b0); push_byte(b1); push_byte(b2); push_byte(b3); push_byte(b4);
   endtask

   task automatic expect5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4);
      exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
      exp_q.push_back(b3); exp_q.push_back(b4);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((rx_fifo.size() != 0 || exp_q.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         failures++;
         $display("FAIL %s_drain got=pending%0d required=pending0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int n;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_rx_rd_en", 128'(rx_rd_en), 128'd0);
      chk("rst_tx_wr_en", 128'(tx_wr_en), 128'd0);
      chk("rst_tx_data", 128'(tx_data), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_err", 128'(frame_err_cnt), 128'd0);
      chk("rst_regs", reg_q, 128'd0);

      // Write reg3 = 0x7E
      expect5(8'h5A, 8'h00, 8'h03, 8'h7E, 8'h7D);
      send5(8'hA5, 8'h01, 8'h03, 8'h7E, 8'h7C);
      wait_idle("write");
      exp_regs[3*8 +: 8] = 8'h7E;
      chk("write_regs", reg_q, exp_regs);
      chk("write_err", 128'(frame_err_cnt), 128'd0);

      // Read reg3
      expect5(8'h5A, 8'h00, 8'h03, 8'h7E, 8'h7D);
      send5(8'hA5, 8'h02, 8'h03, 8'h00, 8'h01);
      wait_idle("read");

      // Bad checksum
      expect5(8'h5A, 8'hE1, 8'h03, 8'h7E, 8'h9C);
      send5(8'hA5, 8'h01, 8'h03, 8'h7E, 8'h00);
      wait_idle("badchk");
      chk("badchk_regs", reg_q, exp_regs);
      chk("badchk_err", 128'(frame_err_cnt), 128'd1);

      // Bad address
      expect5(8'h5A, 8'hE3, 8'h10, 8'h55, 8'hA6);
      send5(8'hA5, 8'h01, 8'h10, 8'h55, 8'h44);
      wait_idle("badaddr");
      chk("badaddr_regs", reg_q, exp_regs);

      // Bad command
      expect5(8'h5A, 8'hE2, 8'h02, 8'h11, 8'hF1);
      send5(8'hA5, 8'h07, 8'h02, 8'h11, 8'h14);
      wait_idle("badcmd");
      chk("badcmd_regs", reg_q, exp_regs);
      chk("badcmd_err", 128'(frame_err_cnt), 128'd1);

      // Resync over junk bytes, then write reg5 = 0x33
      expect5(8'h5A, 8'h00, 8'h05, 8'h33, 8'h36);
      push_byte(8'h00);
      push_byte(8'hFF);
      send5(8'hA5, 8'h01, 8'h05, 8'h33, 8'h37);
      wait_idle("resync");
      exp_regs[5*8 +: 8] = 8'h33;
      chk("resync_regs", reg_q, exp_regs);

      // Partial frame then idle past the timeout
      push_byte(8'hA5);
      push_byte(8'h01);
      repeat (1010) @(negedge clk);
      chk("timeout_err", 128'(frame_err_cnt), 128'd2);
      chk("timeout_busy", 128'(busy), 128'd0);
      expect5(8'h5A, 8'h00, 8'h05, 8'h33, 8'h36);
      send5(8'hA5, 8'h02, 8'h05, 8'h00, 8'h07);
      wait_idle("after_timeout");

      // TX backpressure mid-response
      base = tx_seen;
      expect5(8'h5A, 8'h00, 8'h0A, 8'hC3, 8'hC9);
      send5(8'hA5, 8'h01, 8'h0A, 8'hC3, 8'hC8);
      n = 0;
      while (tx_seen < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("bp_started", 128'(tx_seen >= base + 2), 128'd1);
      @(posedge clk);
      #1;
      tx_full = 1'b1;
      in_window = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      tx_full = 1'b0;
      in_window = 1'b0;
      chk("bp_window_wr", 128'(win_wr), 128'd0);
      wait_idle("backpressure");
      chk("bp_count", 128'(tx_seen - base), 128'd5);
      exp_regs[10*8 +: 8] = 8'hC3;
      chk("bp_regs", reg_q, exp_regs);

      // Reset after three request bytes
      push_byte(8'hA5);
      push_byte(8'h01);
      push_byte(8'h03);
      repeat (12) @(negedge clk);
      chk("mid_busy", 128'(busy), 128'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_rx_rd_en", 128'(rx_rd_en), 128'd0);
      chk("mid_rst_tx_wr_en", 128'(tx_wr_en), 128'd0);
      chk("mid_rst_tx_data", 128'(tx_data), 128'd0);
      chk("mid_rst_busy", 128'(busy), 128'd0);
      chk("mid_rst_err", 128'(frame_err_cnt), 128'd0);
      chk("mid_rst_regs", reg_q, 128'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      exp_regs = '0;
      expect5(8'h5A, 8'h00, 8'h0A, 8'h00, 8'h0A);
      send5(8'hA5, 8'h02, 8'h0A, 8'h00, 8'h08);
      wait_idle("after_reset");
      chk("end_regs", reg_q, exp_regs);
      chk("end_pending", 128'(exp_q.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
